seq_divider: RTL

- Multi-cycle restoring integer divider with a start/ready handshake.
- Runtime-selectable signed or unsigned operation.
- Explicit divide-by-zero reporting.
- Parametrised in operand width. Sits beside the datapath ALU blocks and serves as the reusable division unit for all word sizes.

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Operands are captured on an accepted start; signed operation works on
// magnitudes and fixes the signs up in a single extra cycle, so the quotient
// truncates toward zero and the remainder carries the dividend's sign.
//
// Handshake: start is sampled only while the FSM is IDLE; the accepting edge
// captures the operands and signed_mode. busy is high while the datapath
// iterates (RUN and FIX). ready is a one-cycle pulse and result, remainder and
// div_by_zero are valid from that cycle, holding until the next operation
// writes them. Requests made while not IDLE are dropped, never queued.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high; overrides start
//   start        in   request a division (sampled in IDLE only)
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   dividend     in   [WORD_LENGTH-1:0] numerator
//   divisor      in   [WORD_LENGTH-1:0] denominator
//   busy         out  high while the division iterates
//   ready        out  one-cycle completion pulse
//   result       out  [WORD_LENGTH-1:0] quotient
//   remainder    out  [WORD_LENGTH-1:0] remainder
//   div_by_zero  out  set with ready when the captured divisor was zero
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WORD_LENGTH = 16,
    parameter int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   busy,
    output logic                   ready,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LENGTH - 1);

    logic [1:0]             state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    // quo_q starts as the dividend magnitude; each RUN cycle shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    // On the divide-by-zero path it simply holds the raw dividend.
    logic [WORD_LENGTH-1:0] quo_q;
    logic [WORD_LENGTH-1:0] rem_q;
    logic [WORD_LENGTH-1:0] dvs_q;
    logic                   q_neg_q;
    logic                   r_neg_q;
    logic                   dbz_q;

    logic [WORD_LENGTH-1:0] result_q;
    logic [WORD_LENGTH-1:0] remainder_q;
    logic                   ready_q;
    logic                   div_by_zero_q;

    // Operand conditioning for the accepting edge.
    logic                   dividend_neg;
    logic                   divisor_neg;
    logic [WORD_LENGTH-1:0] dividend_mag;
    logic [WORD_LENGTH-1:0] divisor_mag;

    // One restoring step. Because rem_q < dvs_q always holds, the shifted
    // value is below 2*dvs_q, so WORD_LENGTH+1 bits are enough and the MSB of
    // the difference is a reliable "went negative" flag.
    logic [WORD_LENGTH:0]   shifted;
    logic [WORD_LENGTH:0]   diff;
    logic                   diff_neg;

    // Sign fix-up values used in FIX.
    logic [WORD_LENGTH-1:0] quo_fixed;
    logic [WORD_LENGTH-1:0] rem_fixed;

    always_comb begin
        dividend_neg = signed_mode & dividend[WORD_LENGTH-1];
        divisor_neg  = signed_mode & divisor[WORD_LENGTH-1];
        // Most-negative input maps onto itself, which is the correct
        // unsigned magnitude 2^(WORD_LENGTH-1).
        dividend_mag = dividend_neg ? (WORD_LENGTH'(0) - dividend) : dividend;
        divisor_mag  = divisor_neg  ? (WORD_LENGTH'(0) - divisor)  : divisor;
    end

    always_comb begin
        shifted  = {rem_q, quo_q[WORD_LENGTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        diff_neg = diff[WORD_LENGTH];
    end

    always_comb begin
        quo_fixed = q_neg_q ? (WORD_LENGTH'(0) - quo_q) : quo_q;
        rem_fixed = r_neg_q ? (WORD_LENGTH'(0) - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            result_q      <= '0;
            remainder_q   <= '0;
            ready_q       <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Keep the raw dividend for the remainder output;
                            // the flag itself is raised together with ready.
                            quo_q   <= dividend;
                            dbz_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            quo_q         <= dividend_mag;
                            dvs_q         <= divisor_mag;
                            rem_q         <= '0;
                            cnt_q         <= '0;
                            q_neg_q       <= dividend_neg ^ divisor_neg;
                            r_neg_q       <= dividend_neg;
                            dbz_q         <= 1'b0;
                            div_by_zero_q <= 1'b0;
                            state_q       <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (diff_neg) begin
                        // Restore: shifted < divisor, so its MSB is zero.
                        rem_q <= shifted[WORD_LENGTH-1:0];
                    end else begin
                        rem_q <= diff[WORD_LENGTH-1:0];
                    end
                    quo_q <= {quo_q[WORD_LENGTH-2:0], ~diff_neg};
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    result_q    <= quo_fixed;
                    remainder_q <= rem_fixed;
                    state_q     <= ST_DONE;
                end

                ST_DONE: begin
                    ready_q <= 1'b1;
                    if (dbz_q) begin
                        result_q      <= '1;
                        remainder_q   <= quo_q;
                        div_by_zero_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign ready       = ready_q;
    assign result      = result_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
